// File: rtl/spi_pkg.sv
// spi_pkg: shared types for the configurable SPI master.
// Sequencer states and SPI mode encodings ({cpol, cpha}).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SETUP,
    XFER,
    TAIL
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period tick generator for the SPI master.
// Down-counter reloads with div_i; ticks every div_i+1 enabled cycles.
module spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Reload while disabled or on tick, otherwise count down
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (!en_i || cnt_q == '0) cnt_d = div_i;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with runtime mode, width and divider.
// Sequencer, edge counter, shift registers and held chip select.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  CS_N   = 1,
  parameter int  DIV_W  = 8,
  localparam int SEL_W  = (CS_N > 1) ? $clog2(CS_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic              hold_cs,
  output logic [DATA_W-1:0] data_out,
  output logic              new_data,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_N-1:0]   cs_n
);

  localparam int CNT_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              nd_q, nd_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic [CS_N-1:0]   cs_n_q, cs_n_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              hcs_q, hcs_d;
  logic              held_q, held_d;
  logic              tick, lead, cs_en;

  function automatic logic head(
    input logic [DATA_W-1:0] w,
    input logic              lsb
  );
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift(
    input logic [DATA_W-1:0] w,
    input logic              lsb
  );
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  spi_clkgen #(
    .DIV_W (DIV_W)
  ) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != IDLE),
    .div_i  ((state_q == IDLE) ? clk_div : div_q),
    .tick_o (tick)
  );

  // Next-state, datapath and chip-select decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    nd_d    = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    sel_d   = sel_q;
    hcs_d   = hcs_q;
    held_d  = held_q;
    lead    = 1'b0;
    cs_en   = 1'b0;
    cs_n_d  = '1;
    unique case (state_q)
      IDLE: begin
        if (!held_q) sck_d = cpol;
        if (start) begin
          tx_d   = data_in;
          div_d  = clk_div;
          cpol_d = cpol;
          cpha_d = cpha;
          lsb_d  = lsb_first;
          sel_d  = cs_sel;
          hcs_d  = hold_cs;
          sck_d  = cpol;
          cnt_d  = '0;
          if (!cpha) mosi_d = head(data_in, lsb_first);
          if (held_q && sel_q != cs_sel) state_d = GAP;
          else                           state_d = SETUP;
        end
      end
      GAP: begin
        sck_d = cpol_q;
        if (tick) state_d = SETUP;
      end
      SETUP: begin
        sck_d = cpol_q;
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick) begin
          lead  = ~cnt_q[0];
          sck_d = ~sck_q;
          cnt_d = cnt_q + 1'b1;
          if (lead ^ cpha_q) begin
            rx_d = lsb_q ? {miso, rx_q[DATA_W-1:1]}
                         : {rx_q[DATA_W-2:0], miso};
          end else if (cpha_q) begin
            mosi_d = head(tx_q, lsb_q);
            tx_d   = shift(tx_q, lsb_q);
          end else begin
            tx_d   = shift(tx_q, lsb_q);
            mosi_d = head(tx_d, lsb_q);
          end
          if (cnt_q == LAST) state_d = TAIL;
        end
      end
      TAIL: begin
        sck_d = cpol_q;
        if (tick) begin
          state_d = IDLE;
          nd_d    = 1'b1;
          dout_d  = rx_q;
          held_d  = hcs_q;
        end
      end
      default: state_d = IDLE;
    endcase
    cs_en = (state_d inside {SETUP, XFER, TAIL}) ||
            (state_d == IDLE && held_d);
    for (int i = 0; i < CS_N; i++) begin
      cs_n_d[i] = !(cs_en && (int'(sel_d) == i));
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      nd_q    <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      sel_q   <= '0;
      hcs_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      nd_q    <= nd_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      sel_q   <= sel_d;
      hcs_q   <= hcs_d;
      held_q  <= held_d;
    end
  end

  assign data_out = dout_q;
  assign new_data = nd_q;
  assign busy     = (state_q != IDLE);
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed and randomized checks of spi_master_cfg.
// A bit-level SPI slave model reacts to SCK edges on the pins.
module tb_spi_master_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cpol, cpha, lsb, hold, w16, loop;
  logic [15:0] din;
  logic [7:0]  div;
  logic [1:0]  csel;

  logic [7:0]  dout8;
  logic        nd8, busy8, sck8, mosi8;
  logic [3:0]  csn8;
  logic [15:0] dout16;
  logic        nd16, busy16, sck16, mosi16;
  logic [3:0]  csn16;

  logic [15:0] dout;
  logic        nd, busy, sck, mosi, miso;
  logic [3:0]  csn;
  logic        miso_m = 1'b0;

  assign dout = w16 ? dout16 : {8'h00, dout8};
  assign nd   = w16 ? nd16 : nd8;
  assign busy = w16 ? busy16 : busy8;
  assign sck  = w16 ? sck16 : sck8;
  assign mosi = w16 ? mosi16 : mosi8;
  assign csn  = w16 ? csn16 : csn8;
  assign miso = loop ? mosi : miso_m;

  spi_master_cfg #(.DATA_W(8), .CS_N(4), .DIV_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start && !w16),
    .data_in(din[7:0]), .clk_div(div), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb), .cs_sel(csel),
    .hold_cs(hold), .data_out(dout8), .new_data(nd8),
    .busy(busy8), .sck(sck8), .mosi(mosi8), .miso(miso),
    .cs_n(csn8)
  );

  spi_master_cfg #(.DATA_W(16), .CS_N(4), .DIV_W(8)) u16 (
    .clk(clk), .rst(rst), .start(start && w16),
    .data_in(din), .clk_div(div), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb), .cs_sel(csel),
    .hold_cs(hold), .data_out(dout16), .new_data(nd16),
    .busy(busy16), .sck(sck16), .mosi(mosi16), .miso(miso),
    .cs_n(csn16)
  );

  // Slave model configuration (written by the stimulus)
  int          m_w = 8, m_req = 0;
  bit          m_pol, m_pha, m_lsb, watch = 0;
  logic [15:0] m_rep = '0;
  // Slave model state (written only by the model)
  int          m_ack = 0, m_drv = 0, ecnt = 0, viol = 0;
  logic        m_rx[$];
  logic        act, act_p = 1'b0, sck_p = 1'b0, lead;

  assign act = (csn != 4'hF);

  function automatic logic rbit(input int k);
    return m_lsb ? m_rep[k] : m_rep[m_w-1-k];
  endfunction

  function automatic logic [15:0] rxword(input bit lsbo);
    logic [15:0] v = '0;
    for (int k = 0; k < m_rx.size() && k < m_w; k++)
      if (m_rx[k] === 1'b1) v[lsbo ? k : m_w-1-k] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] csexp(input int s);
    logic [3:0] v = 4'hF;
    v[s] = 1'b0;
    return v;
  endfunction

  // Slave: sample/drive on SCK edges seen while selected
  always @(negedge clk) begin
    if (m_req != m_ack) begin
      m_ack = m_req;
      ecnt  = 0;
      m_rx.delete();
      if (!m_pha) begin
        miso_m = rbit(0);
        m_drv  = 1;
      end else m_drv = 0;
    end
    if (rst) begin
      act_p = 1'b0;
      sck_p = 1'b0;
    end else begin
      if (act && act_p && sck !== sck_p) begin
        ecnt++;
        lead = (sck !== m_pol);
        if (lead != m_pha) m_rx.push_back(mosi);
        else if (m_drv < m_w) begin
          miso_m = rbit(m_drv);
          m_drv++;
        end
      end
      if (watch && csn[2]) viol++;
      act_p = act;
      sck_p = sck;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input bit b16, input logic [15:0] d,
                      input logic [15:0] rep, input int dv,
                      input bit pol, input bit pha, input bit lb,
                      input int sel, input bit hcs, input bit lp,
                      input bit gap);
    int          w, h, c, lat, blo;
    logic [15:0] msk;
    w   = b16 ? 16 : 8;
    h   = dv + 1;
    msk = b16 ? 16'hFFFF : 16'h00FF;
    w16 = b16;
    loop = lp;
    m_w = w; m_pol = pol; m_pha = pha; m_lsb = lb;
    m_rep = rep & msk;
    m_req++;
    din = d; div = 8'(dv); cpol = pol; cpha = pha;
    lsb = lb; csel = 2'(sel); hold = hcs;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din = ~d; div = 8'($urandom_range(0, 255));
    cpha = ~pha; lsb = ~lb; csel = ~csel; hold = ~hcs;
    chk("busy_t1", busy, 1);
    chk("sck_t1", sck, pol);
    chk("csn_t1", csn, gap ? 4'hF : csexp(sel));
    c = 1;
    blo = 0;
    while (!nd && c < 400) begin
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      @(posedge clk); #1;
      c++;
      if (gap && c == h + 1) chk("csn_after_gap", csn, csexp(sel));
      if (!nd && !busy) blo++;
    end
    start = 1'b0;
    lat = 1 + h * (2 * w + 2) + (gap ? h : 0);
    chk("latency", c, lat);
    chk("busy_low_early", blo, 0);
    chk("busy_at_nd", busy, 0);
    chk("data_out", dout, lp ? (d & msk) : (rep & msk));
    chk("dev_rx", rxword(lb), d & msk);
    chk("sck_edges", ecnt, 2 * w);
    chk("csn_end", csn, hcs ? csexp(sel) : 4'hF);
    chk("sck_idle", sck, pol);
  endtask

  initial begin
    int c, ndc;
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
    lsb = 1'b0; hold = 1'b0; w16 = 1'b0; loop = 1'b0;
    din = '0; div = '0; csel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_csn", csn, 4'hF);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_dout", dout, 0);
    chk("rst_nd", nd, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(0, 16'h00A5, 16'h0000, 1, 0, 0, 0, 0, 0, 1, 0);

    cpol = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sck_idle_high", sck, 1);
    xfer(0, 16'h00C3, 16'h003C, 1, 1, 1, 0, 0, 0, 0, 0);

    xfer(0, 16'h0001, 16'h005A, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("lsb_first_bit", m_rx[0], 1);
    chk("msb_read", rxword(0), 16'h0080);

    xfer(1, 16'(($urandom)), 16'h0, 0, 0, 0, 0, 2, 1, 1, 0);
    watch = 1;
    xfer(1, 16'(($urandom)), 16'h0, 0, 0, 0, 0, 2, 1, 1, 0);
    xfer(1, 16'(($urandom)), 16'h0, 0, 0, 0, 0, 2, 1, 1, 0);
    xfer(1, 16'(($urandom)), 16'h0, 0, 0, 0, 0, 2, 0, 1, 0);
    watch = 0;
    chk("burst_cs2_held", viol, 0);

    xfer(0, 16'h0096, 16'h0069, 1, 0, 0, 0, 1, 1, 0, 0);
    xfer(0, 16'h0017, 16'h00E8, 1, 0, 0, 0, 3, 0, 0, 1);

    for (int i = 0; i < 10; i++) begin
      xfer(1'($urandom), 16'($urandom), 16'($urandom),
           $urandom_range(0, 3), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 3), 0,
           1'($urandom), 0);
    end

    w16 = 0; loop = 1;
    m_w = 8; m_pol = 0; m_pha = 0; m_lsb = 0;
    m_req++;
    din = 16'h005A; div = 8'd1; cpol = 0; cpha = 0;
    lsb = 0; csel = 2'd0; hold = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (ecnt < 7 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    chk("reached_edge7", ecnt, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_csn", csn, 4'hF);
    chk("abort_sck", sck, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nd", nd, 0);
    rst = 1'b0;
    ndc = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (nd) ndc++;
    end
    chk("abort_no_nd", ndc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
